// File: rtl/tape_pkg.sv
// Shared constants and sequencer state type for the Oric .TAP image saver.
package tape_pkg;

  localparam logic [7:0] TAP_SYNC      = 8'h16;
  localparam logic [7:0] TAP_START     = 8'h24;
  localparam int         TAP_FIXED_HDR = 11;
  localparam int         TAP_NAME_MAX  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_HDR,
    S_DREQ,
    S_DWAIT,
    S_DRDY,
    S_DONE
  } state_t;

endpackage

// File: rtl/tap_header_rom.sv
// Combinational header-byte generator: maps the header index plus the latched
// region/type fields and the name buffer onto the .TAP header byte.
module tap_header_rom
  import tape_pkg::*;
#(
  parameter int AW         = 16,
  parameter int SYNC_COUNT = 3
) (
  input  logic [7:0]                  idx,
  input  logic [AW-1:0]               start_addr,
  input  logic [AW-1:0]               end_addr,
  input  logic [7:0]                  file_type,
  input  logic [7:0]                  auto_byte,
  input  logic [8*TAP_NAME_MAX-1:0]   name_flat,
  input  logic [4:0]                  name_len,
  output logic [7:0]                  hdr_byte
);

  localparam logic [7:0] P_SYNC = 8'(SYNC_COUNT);

  logic [15:0] w_start16;
  logic [15:0] w_end16;
  logic [7:0]  w_nidx;

  // Addresses are always emitted as 16-bit big-endian words.
  assign w_start16 = 16'(start_addr);
  assign w_end16   = 16'(end_addr);
  assign w_nidx    = idx - (P_SYNC + 8'd10);

  // Header byte select; reserved bytes, the name lead-in and the terminator default to 0x00.
  always_comb begin
    hdr_byte = 8'h00;
    if (idx < P_SYNC) begin
      hdr_byte = TAP_SYNC;
    end else if (idx == P_SYNC) begin
      hdr_byte = TAP_START;
    end else if (idx == P_SYNC + 8'd3) begin
      hdr_byte = file_type;
    end else if (idx == P_SYNC + 8'd4) begin
      hdr_byte = auto_byte;
    end else if (idx == P_SYNC + 8'd5) begin
      hdr_byte = w_end16[15:8];
    end else if (idx == P_SYNC + 8'd6) begin
      hdr_byte = w_end16[7:0];
    end else if (idx == P_SYNC + 8'd7) begin
      hdr_byte = w_start16[15:8];
    end else if (idx == P_SYNC + 8'd8) begin
      hdr_byte = w_start16[7:0];
    end else if (idx >= P_SYNC + 8'd10) begin
      for (int k = 0; k < TAP_NAME_MAX; k++) begin
        if ((w_nidx == 8'(k)) && (5'(k) < name_len)) begin
          hdr_byte = name_flat[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/tape_saver.sv
// Oric .TAP image saver: builds the header, then streams RAM[start..end] over
// the ioctl upload channel one byte per host read.
// Optional file name support is enabled by defining TAPE_SAVER_NAME_EN.
module tape_saver
  import tape_pkg::*;
#(
  parameter int AW         = 16,
  parameter int SYNC_COUNT = 3
) (
  input  logic          clk,
  input  logic          reset,
`ifdef TAPE_SAVER_NAME_EN
  input  logic          name_wr,
  input  logic [3:0]    name_idx,
  input  logic [7:0]    name_char,
`endif
  input  logic          save_start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW-1:0] end_addr,
  input  logic [7:0]    file_type,
  input  logic [7:0]    auto_byte,
  output logic [AW-1:0] ram_a,
  output logic          ram_rd,
  input  logic [7:0]    ram_q,
  input  logic          ioctl_upload,
  input  logic          ioctl_rd,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic [23:0]   file_size,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [7:0] P_HDR_BASE = 8'(SYNC_COUNT + TAP_FIXED_HDR);

  state_t                    r_state;
  state_t                    w_state_next;
  logic [AW-1:0]             r_start;
  logic [AW-1:0]             r_end;
  logic [AW-1:0]             r_ptr;
  logic [7:0]                r_type;
  logic [7:0]                r_auto;
  logic [7:0]                r_idx;
  logic [7:0]                r_data;
  logic [23:0]               r_file_size;
  logic                      r_err;
  logic [4:0]                w_name_len;
  logic [8*TAP_NAME_MAX-1:0] w_name_flat;
  logic [7:0]                w_hdr_len;
  logic [7:0]                w_hdr_byte;
  logic [AW:0]               w_data_len;
  logic                      w_rd_ok;
  logic                      w_last_hdr;
  logic                      w_accept;
  logic                      w_reject;

`ifdef TAPE_SAVER_NAME_EN
  logic [7:0] r_name [TAP_NAME_MAX];

  // Name buffer: writable only while idle so a running save sees a stable name.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TAP_NAME_MAX; k++) r_name[k] <= 8'h00;
    end else if (name_wr && (r_state == S_IDLE)) begin
      r_name[name_idx] <= name_char;
    end
  end

  for (genvar gi = 0; gi < TAP_NAME_MAX; gi++) begin : g_name
    assign w_name_flat[8*gi +: 8] = r_name[gi];
  end

  // Name length = position of the first NUL, or the full buffer when none.
  always_comb begin
    w_name_len = 5'd16;
    for (int k = TAP_NAME_MAX - 1; k >= 0; k--) begin
      if (r_name[k] == 8'h00) w_name_len = 5'(k);
    end
  end
`else
  assign w_name_flat = '0;
  assign w_name_len  = 5'd0;
`endif

  // Data length is one bit wider than the address so a full-space save yields 2^AW.
  assign w_hdr_len  = P_HDR_BASE + {3'b000, w_name_len};
  assign w_data_len = {1'b0, r_end} - {1'b0, r_start} + {{AW{1'b0}}, 1'b1};
  assign w_rd_ok    = ioctl_rd & ioctl_upload;
  assign w_last_hdr = (r_idx == (w_hdr_len - 8'd1));
  assign w_accept   = save_start && (r_state == S_IDLE) && (end_addr >= start_addr);
  assign w_reject   = save_start && (r_state == S_IDLE) && (end_addr < start_addr);

  tap_header_rom #(
    .AW         (AW),
    .SYNC_COUNT (SYNC_COUNT)
  ) u_hdr (
    .idx        (r_idx),
    .start_addr (r_start),
    .end_addr   (r_end),
    .file_type  (r_type),
    .auto_byte  (r_auto),
    .name_flat  (w_name_flat),
    .name_len   (w_name_len),
    .hdr_byte   (w_hdr_byte)
  );

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Next state and per-state outputs; a dropped upload window aborts without a done pulse.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    ioctl_wait   = 1'b1;
    ioctl_din    = r_data;
    ram_rd       = 1'b0;
    ram_a        = '0;
    done         = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_next = S_ARM;
      end
      S_ARM: begin
        busy = 1'b1;
        if (ioctl_upload) w_state_next = S_HDR;
      end
      S_HDR: begin
        busy       = 1'b1;
        ioctl_wait = 1'b0;
        ioctl_din  = w_hdr_byte;
        if (!ioctl_upload)              w_state_next = S_IDLE;
        else if (ioctl_rd && w_last_hdr) w_state_next = S_DREQ;
      end
      S_DREQ: begin
        busy   = 1'b1;
        ram_rd = 1'b1;
        ram_a  = r_ptr;
        w_state_next = ioctl_upload ? S_DWAIT : S_IDLE;
      end
      S_DWAIT: begin
        busy = 1'b1;
        w_state_next = ioctl_upload ? S_DRDY : S_IDLE;
      end
      S_DRDY: begin
        busy       = 1'b1;
        ioctl_wait = 1'b0;
        if (!ioctl_upload) w_state_next = S_IDLE;
        else if (ioctl_rd) w_state_next = (r_ptr == r_end) ? S_DONE : S_DREQ;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath: field latch on accept, size register, header index, data pointer and data byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_start     <= '0;
      r_end       <= '0;
      r_ptr       <= '0;
      r_type      <= 8'h00;
      r_auto      <= 8'h00;
      r_idx       <= 8'h00;
      r_data      <= 8'h00;
      r_file_size <= 24'h0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (w_accept) begin
        r_start <= start_addr;
        r_end   <= end_addr;
        r_ptr   <= start_addr;
        r_type  <= file_type;
        r_auto  <= auto_byte;
        r_idx   <= 8'h00;
      end
      if (r_state == S_ARM) begin
        r_file_size <= 24'(w_data_len) + 24'(w_hdr_len);
      end
      if ((r_state == S_HDR) && w_rd_ok && !w_last_hdr) begin
        r_idx <= r_idx + 8'd1;
      end
      if (r_state == S_DWAIT) begin
        r_data <= ram_q;
      end
      if ((r_state == S_DRDY) && w_rd_ok && (r_ptr != r_end)) begin
        r_ptr <= r_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign err       = r_err;
  assign file_size = r_file_size;

endmodule

// File: tb/tb_tape_saver.sv
// Self-checking bench for tape_saver: random RAM content and host pacing,
// expected stream built from the .TAP layout rules.
// Define TAPE_SAVER_NAME_EN to exercise the file name option (name "AB").
`timescale 1ns/1ps
module tb_tape_saver;

  localparam int AW         = 16;
  localparam int SYNC_COUNT = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          save_start = 1'b0;
  logic [15:0]   start_addr = '0;
  logic [15:0]   end_addr = '0;
  logic [7:0]    file_type = '0;
  logic [7:0]    auto_byte = '0;
  logic [15:0]   ram_a;
  logic          ram_rd;
  logic [7:0]    ram_q = 8'h00;
  logic          ioctl_upload = 1'b0;
  logic          ioctl_rd = 1'b0;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic [23:0]   file_size;
  logic          busy;
  logic          done;
  logic          err;
`ifdef TAPE_SAVER_NAME_EN
  logic          name_wr = 1'b0;
  logic [3:0]    name_idx = '0;
  logic [7:0]    name_char = '0;
  string         tb_name = "AB";
`else
  string         tb_name = "";
`endif

  logic [7:0] mem [65536];
  logic [7:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int strobe_cnt = 0;

  tape_saver #(.AW(AW), .SYNC_COUNT(SYNC_COUNT)) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef TAPE_SAVER_NAME_EN
    .name_wr      (name_wr),
    .name_idx     (name_idx),
    .name_char    (name_char),
`endif
    .save_start   (save_start),
    .start_addr   (start_addr),
    .end_addr     (end_addr),
    .file_type    (file_type),
    .auto_byte    (auto_byte),
    .ram_a        (ram_a),
    .ram_rd       (ram_rd),
    .ram_q        (ram_q),
    .ioctl_upload (ioctl_upload),
    .ioctl_rd     (ioctl_rd),
    .ioctl_din    (ioctl_din),
    .ioctl_wait   (ioctl_wait),
    .file_size    (file_size),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  // RAM model: data valid one cycle after the read strobe.
  always @(posedge clk) if (ram_rd) ram_q <= mem[ram_a];

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (ram_rd === 1'b1) strobe_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference image: leader, header fields, name, terminator, then the RAM bytes.
  function automatic void build_expected(input logic [15:0] s, input logic [15:0] e,
                                         input logic [7:0] t, input logic [7:0] a);
    exp_q.delete();
    for (int i = 0; i < SYNC_COUNT; i++) exp_q.push_back(8'h16);
    exp_q.push_back(8'h24);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(t);
    exp_q.push_back(a);
    exp_q.push_back(e[15:8]);
    exp_q.push_back(e[7:0]);
    exp_q.push_back(s[15:8]);
    exp_q.push_back(s[7:0]);
    exp_q.push_back(8'h00);
    for (int i = 0; i < tb_name.len(); i++) exp_q.push_back(8'(tb_name[i]));
    exp_q.push_back(8'h00);
    for (int ad = int'(s); ad <= int'(e); ad++) exp_q.push_back(mem[ad]);
  endfunction

  task automatic start_save(input logic [15:0] s, input logic [15:0] e,
                            input logic [7:0] t, input logic [7:0] a);
    @(negedge clk);
    start_addr = s; end_addr = e; file_type = t; auto_byte = a; save_start = 1'b1;
    @(negedge clk);
    save_start = 1'b0;
  endtask

  // Host side: wait for valid data (optionally pulsing junk reads), compare, consume.
  task automatic read_bytes(input int first, input int count, input bit junk, input string tag);
    for (int i = first; i < first + count; i++) begin
      int cyc;
      cyc = 0;
      @(negedge clk);
      ioctl_rd = 1'b0;
      while (ioctl_wait !== 1'b0 && cyc < 40) begin
        ioctl_rd = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        cyc++;
      end
      n_cmp++;
      if (ioctl_wait !== 1'b0) begin
        n_bad++;
        $display("FAIL %s byte %0d: ioctl_wait=%b after %0d cycles, required 0", tag, i, ioctl_wait, cyc);
        ioctl_rd = 1'b0;
        return;
      end
      if (ioctl_din !== exp_q[i]) begin
        n_bad++;
        $display("FAIL %s byte %0d: ioctl_din=%02h required %02h", tag, i, ioctl_din, exp_q[i]);
      end else begin
        $display("  %s byte %0d = %02h", tag, i, ioctl_din);
      end
      ioctl_rd = 1'b1;
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        ioctl_rd = 1'b0;
      end
    end
    @(negedge clk);
    ioctl_rd = 1'b0;
  endtask

  task automatic run_save(input logic [15:0] s, input logic [15:0] e, input logic [7:0] t,
                          input logic [7:0] a, input bit junk, input bit late, input string tag);
    int d0, r0, len;
    build_expected(s, e, t, a);
    len = int'(e) - int'(s) + 1;
    d0 = done_cnt;
    r0 = strobe_cnt;
    ioctl_upload = late ? 1'b0 : 1'b1;
    start_save(s, e, t, a);
    if (late) begin
      repeat ($urandom_range(1, 4)) begin
        n_cmp++;
        if (busy !== 1'b1 || ioctl_wait !== 1'b1) begin
          n_bad++;
          $display("FAIL %s arm: busy=%b ioctl_wait=%b required 1/1", tag, busy, ioctl_wait);
        end
        @(negedge clk);
      end
      ioctl_upload = 1'b1;
    end
    @(negedge clk);
    n_cmp++;
    if (file_size !== 24'(exp_q.size())) begin
      n_bad++;
      $display("FAIL %s file_size: got %0d required %0d", tag, file_size, exp_q.size());
    end
    read_bytes(0, exp_q.size(), junk, tag);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_bad++;
      $display("FAIL %s done pulses: got %0d required 1", tag, done_cnt - d0);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy after done: got %b required 0", tag, busy);
    end
    n_cmp++;
    if (strobe_cnt - r0 !== len) begin
      n_bad++;
      $display("FAIL %s ram strobes: got %0d required %0d", tag, strobe_cnt - r0, len);
    end
    $display("  %s: save %04h..%04h type %02h auto %02h size %0d", tag, s, e, t, a, exp_q.size());
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset busy: got %b required 0", busy); end
    n_cmp++; if (done !== 1'b0)       begin n_bad++; $display("FAIL reset done: got %b required 0", done); end
    n_cmp++; if (err !== 1'b0)        begin n_bad++; $display("FAIL reset err: got %b required 0", err); end
    n_cmp++; if (ioctl_wait !== 1'b1) begin n_bad++; $display("FAIL reset ioctl_wait: got %b required 1", ioctl_wait); end
    n_cmp++; if (ioctl_din !== 8'h00) begin n_bad++; $display("FAIL reset ioctl_din: got %02h required 00", ioctl_din); end
    n_cmp++; if (ram_rd !== 1'b0)     begin n_bad++; $display("FAIL reset ram_rd: got %b required 0", ram_rd); end
    n_cmp++; if (ram_a !== 16'h0)     begin n_bad++; $display("FAIL reset ram_a: got %04h required 0000", ram_a); end
    n_cmp++; if (file_size !== 24'h0) begin n_bad++; $display("FAIL reset file_size: got %0d required 0", file_size); end
    reset = 1'b0;
    $display("  reset: outputs checked");
  endtask

`ifdef TAPE_SAVER_NAME_EN
  task automatic load_name();
    for (int i = 0; i < tb_name.len(); i++) begin
      @(negedge clk);
      name_wr = 1'b1; name_idx = 4'(i); name_char = 8'(tb_name[i]);
    end
    @(negedge clk);
    name_wr = 1'b0;
  endtask
`endif

  task automatic test_basic();
    mem[16'h0500] = 8'hAA; mem[16'h0501] = 8'hBB; mem[16'h0502] = 8'hCC; mem[16'h0503] = 8'hDD;
    run_save(16'h0500, 16'h0503, 8'h80, 8'h00, 1'b0, 1'b0, "basic");
  endtask

  task automatic test_no_skip();
    run_save(16'h0500, 16'h0503, 8'h80, 8'h00, 1'b1, 1'b0, "junk_rd");
  endtask

  task automatic test_err();
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    start_addr = 16'h1000; end_addr = 16'h0FFF; save_start = 1'b1;
    @(negedge clk);
    save_start = 1'b0;
    n_cmp++; if (err !== 1'b1)        begin n_bad++; $display("FAIL err pulse: got %b required 1", err); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL err busy: got %b required 0", busy); end
    n_cmp++; if (ioctl_wait !== 1'b1) begin n_bad++; $display("FAIL err ioctl_wait: got %b required 1", ioctl_wait); end
    @(negedge clk);
    n_cmp++; if (err !== 1'b0)        begin n_bad++; $display("FAIL err width: got %b required 0", err); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL err busy later: got %b required 0", busy); end
    n_cmp++; if (done_cnt !== d0)     begin n_bad++; $display("FAIL err done: got %0d required %0d", done_cnt, d0); end
    $display("  err: 1000..0FFF rejected");
  endtask

  task automatic test_top_addr();
    mem[16'hFFFF] = 8'h5A;
    run_save(16'hFFFF, 16'hFFFF, 8'h00, 8'hC7, 1'b0, 1'b0, "top_addr");
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_cnt;
    build_expected(16'h0500, 16'h0503, 8'h80, 8'h00);
    ioctl_upload = 1'b1;
    start_save(16'h0500, 16'h0503, 8'h80, 8'h00);
    read_bytes(0, 6, 1'b0, "abort");
    ioctl_upload = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort busy: got %b required 0", busy); end
    repeat (4) @(negedge clk);
    n_cmp++; if (done_cnt !== d0) begin n_bad++; $display("FAIL abort done: got %0d pulses required 0", done_cnt - d0); end
    $display("  abort: upload dropped after 6 bytes");
    run_save(16'h0500, 16'h0503, 8'h80, 8'h00, 1'b0, 1'b0, "restart");
  endtask

  task automatic test_busy_ignore();
    int d0, sz;
    for (int ad = 16'h0200; ad <= 16'h0209; ad++) mem[ad] = 8'($urandom);
    d0 = done_cnt;
    build_expected(16'h0200, 16'h0209, 8'h00, 8'hC7);
    sz = exp_q.size();
    ioctl_upload = 1'b1;
    start_save(16'h0200, 16'h0209, 8'h00, 8'hC7);
    read_bytes(0, 8, 1'b0, "busy_ign");
    start_save(16'h3000, 16'h3005, 8'h55, 8'h80);
    @(negedge clk);
    n_cmp++; if (file_size !== 24'(sz)) begin n_bad++; $display("FAIL busy_ign file_size: got %0d required %0d", file_size, sz); end
    read_bytes(8, sz - 8, 1'b1, "busy_ign");
    repeat (3) @(negedge clk);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL busy_ign done: got %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int r0, d0;
    build_expected(16'h0100, 16'h011F, 8'h80, 8'h80);
    ioctl_upload = 1'b1;
    start_save(16'h0100, 16'h011F, 8'h80, 8'h80);
    read_bytes(0, 14 + tb_name.len() + 3, 1'b0, "rst_mid");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    r0 = strobe_cnt;
    d0 = done_cnt;
    repeat (8) begin
      ioctl_rd = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    ioctl_rd = 1'b0;
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL rst_mid busy: got %b required 0", busy); end
    n_cmp++; if (ioctl_wait !== 1'b1) begin n_bad++; $display("FAIL rst_mid ioctl_wait: got %b required 1", ioctl_wait); end
    n_cmp++; if (strobe_cnt !== r0)   begin n_bad++; $display("FAIL rst_mid strobes: got %0d required 0", strobe_cnt - r0); end
    n_cmp++; if (done_cnt !== d0)     begin n_bad++; $display("FAIL rst_mid done: got %0d required 0", done_cnt - d0); end
    $display("  rst_mid: reset during data phase");
  endtask

  task automatic test_random();
    logic [7:0] types [3];
    types[0] = 8'h00; types[1] = 8'h80; types[2] = 8'hC7;
    for (int n = 0; n < 6; n++) begin
      int len, s;
      len = $urandom_range(1, 24);
      s   = $urandom_range(0, 65536 - len);
      run_save(16'(s), 16'(s + len - 1), types[$urandom_range(0, 1)], types[$urandom_range(0, 2)],
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    test_reset();
`ifdef TAPE_SAVER_NAME_EN
    load_name();
`endif
    test_basic();
    test_err();
    test_top_addr();
    test_no_skip();
    test_abort();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
